button_pulse_conditioner: RTL and testbench

Front-end conditioner for the duty-cycle push-buttons. It converts raw, bouncing, asynchronous increment/decrement buttons into clean single-clock pulses. These pulses drive the increment/decrement inputs of the PWM generator directly. It provides metastability synchronisation, counter-based debounce, press-edge pulse generation, optional hold-to-auto-repeat, and lockout when both buttons are pressed together.

---
 rtl/button_pulse_conditioner.sv | 174 +++++++++++++++++
 tb/tb_button_pulse_conditioner.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/button_pulse_conditioner.sv
// Push-button front end for the PWM duty-cycle controls.
// Turns raw, bouncing, asynchronous increment/decrement buttons into clean
// single-clock request pulses. It provides auto-repeat while a button is
// held, and a lockout while both buttons are pressed together.
//
// Ports:
//   clock        system clock
//   reset        asynchronous, active-high reset
//   btn_inc_raw  raw increment button (asynchronous, active-high)
//   btn_dec_raw  raw decrement button (asynchronous, active-high)
//   repeat_en    1 = auto-repeat while held, 0 = one pulse per press
//   inc_pulse    one-clock increment request
//   dec_pulse    one-clock decrement request
//   inc_level    debounced increment button level
//   dec_level    debounced decrement button level
//   lockout      both-pressed lockout active on either channel
module button_pulse_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_RATE     = 10000000,
    parameter int unsigned CNT_W           = 27
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_inc_raw,
    input  logic btn_dec_raw,
    input  logic repeat_en,
    output logic inc_pulse,
    output logic dec_pulse,
    output logic inc_level,
    output logic dec_level,
    output logic lockout
);

    localparam int unsigned NCH = 2;   // channel 0 = inc, channel 1 = dec

    // Counters compare against "last value" so an event lands on the Nth cycle.
    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT, LOCK} state_t;

    logic [NCH-1:0]   raw;
    logic [NCH-1:0]   sync1;
    logic [NCH-1:0]   sync2;
    logic [NCH-1:0]   level;
    logic [CNT_W-1:0] db_cnt [NCH];

    state_t           state     [NCH];
    state_t           state_nxt [NCH];
    logic [CNT_W-1:0] timer     [NCH];
    logic [CNT_W-1:0] timer_nxt [NCH];
    logic [NCH-1:0]   pulse_nxt;
    logic             lockout_nxt;
    logic             both_c;

    assign raw       = {btn_dec_raw, btn_inc_raw};
    assign inc_level = level[0];
    assign dec_level = level[1];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Two-flop synchroniser for the asynchronous button inputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Debounce: level toggles only after DEBOUNCE_CYCLES consecutive mismatches.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level <= '0;
            for (int i = 0; i < NCH; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (sync2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    level[i]  <= ~level[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Per-channel press/repeat/lock FSM state and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                state[i] <= IDLE;
                timer[i] <= '0;
            end
            inc_pulse <= 1'b0;
            dec_pulse <= 1'b0;
            lockout   <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state[i] <= state_nxt[i];
                timer[i] <= timer_nxt[i];
            end
            inc_pulse <= pulse_nxt[0];
            dec_pulse <= pulse_nxt[1];
            lockout   <= lockout_nxt;
        end
    end

    // Next-state logic. Both levels high overrides everything, so pulses can
    // never fire on both channels at once.
    always_comb begin
        both_c    = &level;
        pulse_nxt = '0;
        for (int i = 0; i < NCH; i++) begin
            state_nxt[i] = state[i];
            timer_nxt[i] = timer[i];
            if (both_c) begin
                state_nxt[i] = LOCK;
            end else begin
                case (state[i])
                    // Level high in IDLE can only follow a fresh debounced rise.
                    IDLE: begin
                        if (level[i]) begin
                            state_nxt[i] = HOLD;
                            pulse_nxt[i] = 1'b1;
                            timer_nxt[i] = '0;
                        end
                    end
                    HOLD: begin
                        if (!level[i]) begin
                            state_nxt[i] = IDLE;
                        end else if (!repeat_en) begin
                            timer_nxt[i] = '0;
                        end else if (timer[i] >= DELAY_LAST) begin
                            state_nxt[i] = REPEAT;
                            pulse_nxt[i] = 1'b1;
                            timer_nxt[i] = '0;
                        end else begin
                            timer_nxt[i] = sat_inc(timer[i]);
                        end
                    end
                    REPEAT: begin
                        if (!level[i]) begin
                            state_nxt[i] = IDLE;
                        end else if (!repeat_en) begin
                            state_nxt[i] = HOLD;
                            timer_nxt[i] = '0;
                        end else if (timer[i] >= RATE_LAST) begin
                            pulse_nxt[i] = 1'b1;
                            timer_nxt[i] = '0;
                        end else begin
                            timer_nxt[i] = sat_inc(timer[i]);
                        end
                    end
                    // A held button must be released before it can press again.
                    LOCK: begin
                        if (!level[i]) state_nxt[i] = IDLE;
                    end
                    default: state_nxt[i] = IDLE;
                endcase
            end
        end
        lockout_nxt = (state_nxt[0] == LOCK) || (state_nxt[1] == LOCK);
    end

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Directed bench for button_pulse_conditioner with a pulse scoreboard:
// expected pulse edges are queued as stimulus is applied and compared
// against the edges at which the DUT actually pulses.
module tb_button_pulse_conditioner;

    localparam int unsigned D  = 4;
    localparam int unsigned DL = 20;
    localparam int unsigned RT = 8;

    logic clock = 1'b0;
    logic reset;
    logic btn_inc_raw;
    logic btn_dec_raw;
    logic repeat_en;
    logic inc_pulse;
    logic dec_pulse;
    logic inc_level;
    logic dec_level;
    logic lockout;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int both_cnt = 0;
    int exp_inc[$];
    int exp_dec[$];
    int obs_inc[$];
    int obs_dec[$];

    button_pulse_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (DL),
        .REPEAT_RATE    (RT),
        .CNT_W          (27)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .btn_inc_raw(btn_inc_raw),
        .btn_dec_raw(btn_dec_raw),
        .repeat_en  (repeat_en),
        .inc_pulse  (inc_pulse),
        .dec_pulse  (dec_pulse),
        .inc_level  (inc_level),
        .dec_level  (dec_level),
        .lockout    (lockout)
    );

    always #5 clock = ~clock;

    // Edge counter: at a negedge, cyc is the number of the last posedge.
    always @(posedge clock) cyc <= cyc + 1;

    // Record the edge at which each pulse was produced.
    always @(negedge clock) begin
        if (!reset) begin
            if (inc_pulse) obs_inc.push_back(cyc);
            if (dec_pulse) obs_dec.push_back(cyc);
            if (inc_pulse && dec_pulse) both_cnt++;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clock);
    endtask

    task automatic check_pulses(input string tag);
        chk({tag, "_inc_count"}, obs_inc.size(), exp_inc.size());
        chk({tag, "_dec_count"}, obs_dec.size(), exp_dec.size());
        while (exp_inc.size() > 0 && obs_inc.size() > 0)
            chk({tag, "_inc_edge"}, obs_inc.pop_front(), exp_inc.pop_front());
        while (exp_dec.size() > 0 && obs_dec.size() > 0)
            chk({tag, "_dec_edge"}, obs_dec.pop_front(), exp_dec.pop_front());
        exp_inc.delete();
        exp_dec.delete();
        obs_inc.delete();
        obs_dec.delete();
    endtask

    initial begin
        int e0;
        int e1;
        int r;
        logic lv;

        reset       = 1'b1;
        btn_inc_raw = 1'b0;
        btn_dec_raw = 1'b0;
        repeat_en   = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Reset state
        chk("rst_inc_pulse", 32'(inc_pulse), 0);
        chk("rst_dec_pulse", 32'(dec_pulse), 0);
        chk("rst_inc_level", 32'(inc_level), 0);
        chk("rst_dec_level", 32'(dec_level), 0);
        chk("rst_lockout",   32'(lockout),   0);

        // 1. Clean press, repeat disabled: one pulse, none on release
        e0 = cyc + 1;
        btn_inc_raw = 1'b1;
        exp_inc.push_back(e0 + D + 2);
        wait_cyc(e0 + D);
        chk("t1_level_before", 32'(inc_level), 0);
        wait_cyc(e0 + D + 1);
        chk("t1_level_rise", 32'(inc_level), 1);
        wait_cyc(e0 + 9);
        btn_inc_raw = 1'b0;
        wait_cyc(e0 + 30);
        chk("t1_level_after", 32'(inc_level), 0);
        check_pulses("t1");

        // 2. Bounce shorter than the debounce window is filtered
        e0 = cyc + 1;
        btn_dec_raw = 1'b1;
        wait_cyc(e0 + 2);
        btn_dec_raw = 1'b0;
        wait_cyc(e0 + 3);
        btn_dec_raw = 1'b1;
        wait_cyc(e0 + 6);
        btn_dec_raw = 1'b0;
        lv = 1'b0;
        while (cyc < e0 + 20) begin
            @(negedge clock);
            lv = lv | dec_level;
        end
        chk("t2_dec_level", 32'(lv), 0);
        check_pulses("t2");

        // 3. Auto-repeat while held for 60 cycles
        repeat_en = 1'b1;
        e0 = cyc + 1;
        btn_inc_raw = 1'b1;
        exp_inc.push_back(e0 + D + 2);
        for (int k = 0; k < 5; k++) exp_inc.push_back(e0 + D + 2 + DL + k * RT);
        wait_cyc(e0 + 59);
        btn_inc_raw = 1'b0;
        wait_cyc(e0 + 80);
        check_pulses("t3");

        // 4. Simultaneous press lockout
        repeat_en = 1'b0;
        e0 = cyc + 1;
        btn_inc_raw = 1'b1;
        exp_inc.push_back(e0 + D + 2);
        wait_cyc(e0 + 9);
        btn_dec_raw = 1'b1;
        wait_cyc(e0 + 10 + D + 1);
        chk("t4_lockout_pre", 32'(lockout), 0);
        wait_cyc(e0 + 10 + D + 2);
        chk("t4_lockout_on", 32'(lockout), 1);
        wait_cyc(e0 + 29);
        btn_dec_raw = 1'b0;
        wait_cyc(e0 + 45);
        chk("t4_lockout_held", 32'(lockout), 1);
        chk("t4_dec_level_low", 32'(dec_level), 0);
        wait_cyc(e0 + 49);
        btn_inc_raw = 1'b0;
        wait_cyc(e0 + 60);
        chk("t4_lockout_off", 32'(lockout), 0);
        e1 = cyc + 1;
        btn_inc_raw = 1'b1;
        exp_inc.push_back(e1 + D + 2);
        wait_cyc(e1 + 9);
        btn_inc_raw = 1'b0;
        wait_cyc(e1 + 30);
        check_pulses("t4");

        // 5. Asynchronous reset in the middle of auto-repeat
        repeat_en = 1'b1;
        e0 = cyc + 1;
        btn_inc_raw = 1'b1;
        exp_inc.push_back(e0 + D + 2);
        exp_inc.push_back(e0 + D + 2 + DL);
        exp_inc.push_back(e0 + D + 2 + DL + RT);
        wait_cyc(e0 + D + 2 + DL + RT);
        chk("t5_pulse_before_reset", 32'(inc_pulse), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_async_inc_pulse", 32'(inc_pulse), 0);
        chk("t5_async_inc_level", 32'(inc_level), 0);
        chk("t5_async_lockout",   32'(lockout),   0);
        check_pulses("t5_pre");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        r = cyc;

        // 6. Held through reset release, then repeat_en dropped and restored
        exp_inc.push_back(r + D + 3);
        exp_inc.push_back(r + D + 3 + DL);
        wait_cyc(r + 30);
        repeat_en = 1'b0;
        wait_cyc(r + 60);
        repeat_en = 1'b1;
        exp_inc.push_back(r + 60 + DL);
        exp_inc.push_back(r + 60 + DL + RT);
        exp_inc.push_back(r + 60 + DL + 2 * RT);
        wait_cyc(r + 90);
        btn_inc_raw = 1'b0;
        wait_cyc(r + 120);
        check_pulses("t6");

        chk("no_overlap", both_cnt, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
